uart_rx_core: RTL
=================

Name: uart_rx_core

Overview:
Parametrised UART receiver with oversampled start-bit validation, configurable frame format, and a one-word valid/ready output buffer. It carries per-word error flags and a sticky overrun flag. It converts the asynchronous serial line into a handshaked parallel stream for the uart_protocol layer. This is the receive half of the next-generation UART; width, stop bits, oversampling and baud divisor are all parameters.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
STOP_BITS, 1, number of stop bits; 1 or 2.
OVERSAMPLE, 16, baud ticks per bit; even, 8..32.
CLK_DIV, 27, clk cycles per baud tick; must be at least 2.
PARITY_ODD, 0, 1 = odd parity, 0 = even parity; used only when UART_RX_PARITY_EN is defined.

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
rx  in  1  serial line; asynchronous to clk; idles high
rx_data  out  DATA_BITS  received word, LSB first on the line
rx_valid  out  1  rx_data and the error flags are valid
rx_ready  in  1  consumer accepts the word
frame_err  out  1  a stop bit sampled 0; qualified by rx_valid
parity_err  out  1  parity mismatch; qualified by rx_valid
overrun  out  1  sticky: a word was dropped because the buffer was full
ovr_clr  in  1  single-cycle clear of overrun
busy  out  1  FSM is not in IDLE

Behaviour:
Reset values:
- All outputs are 0.
- rx synchroniser flops reset to 1.
- FSM resets to IDLE; tick and sample counters reset to 0.
- Reset takes effect mid-frame without qualification: any partial word is discarded.

Input synchroniser:
- rx passes through a 2-flop synchroniser before any use (2-cycle latency).
- All rx references below mean the synchronised value.

Baud tick:
- Free-running counter 0..CLK_DIV-1.
- tick asserts for one cycle when the counter equals CLK_DIV-1, then wraps to 0.

FSM (all transitions are taken on tick unless stated otherwise):
- IDLE: on rx==0, go to START with scnt=0.
- START: scnt increments each tick. When scnt==OVERSAMPLE/2-1, sample rx:
  - rx==1: glitch; return to IDLE.
  - rx==0: go to DATA with scnt=0 and bit index 0.
- DATA: sample rx when scnt==OVERSAMPLE-1 (mid-bit), then reset scnt.
  - Shift the sample into the MSB of the shift register (right shift), giving LSB-first assembly.
  - After DATA_BITS samples, go to PARITY if the macro is defined, otherwise STOP.
- PARITY: one mid-bit sample, then go to STOP.
- STOP: STOP_BITS mid-bit samples. Any sample of 0 sets the frame-error latch. After the last sample, commit:
  - Frame error: go to BREAK.
  - Otherwise: go to IDLE in the same cycle, so a back-to-back start bit half a bit later is caught.
- BREAK: wait for rx==1 (no tick needed), then go to IDLE. This prevents a held-low line from producing repeated frames.

Commit (single cycle):
- The buffer is free when rx_valid==0, or when rx_valid && rx_ready in that same cycle.
- If free:
  - rx_data is loaded with the shift register, right-aligned.
  - frame_err and parity_err are loaded with their latches.
  - rx_valid is set to 1.
- If not free: the word and its flags are dropped, rx_data is unchanged, and overrun is set to 1.

Output handshake:
- rx_valid is held until rx_valid && rx_ready; it is then cleared unless a commit occurs in the same cycle.
- rx_data, frame_err and parity_err are stable while rx_valid==1.

overrun:
- Cleared by ovr_clr.
- If a set and ovr_clr occur in the same cycle, set wins.

busy is 1 in every state except IDLE.

Optional Feature:
Macro: UART_RX_PARITY_EN.
- Defined:
  - The PARITY state exists.
  - Expected parity bit = XOR of the data bits, XOR PARITY_ODD.
  - parity_err = (sampled parity bit != expected parity bit).
- Not defined:
  - No PARITY state; the frame is start, DATA_BITS data bits, then STOP_BITS stop bits.
  - parity_err is tied to 0.

Test Plan:
Common settings: CLK_DIV=4, OVERSAMPLE=16, so one bit = 64 clk cycles. Default frame is 8N1 with rx_ready=1.
1. Drive 0xA5 -> rx_valid high for exactly 1 cycle, rx_data=0xA5, frame_err=0. rx_valid rises 9.5 bit times after the start edge (608 cycles), within ±(CLK_DIV+3) cycles.
2. Pulse rx low for 20 cycles, then hold it high -> no rx_valid; busy returns to 0 within 40 cycles.
3. Drive 0x3C with a stop bit of 0, then hold rx low for 5 bit times -> one rx_valid with rx_data=0x3C and frame_err=1. No second word arrives until rx goes high and a new start bit is sent; a following 0x55 is received cleanly.
4. With rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, rx_valid=1, overrun=1. Then:
   - Pulse ovr_clr -> overrun=0.
   - Assert rx_ready -> rx_valid drops next cycle.
5. With UART_RX_PARITY_EN defined and PARITY_ODD=0:
   - Send 0x07 with parity bit 0 -> parity_err=1.
   - Send 0x07 with parity bit 1 -> parity_err=0.
6. Deassert reset_n during data bit 4 of a frame -> all outputs read 0 while reset is asserted. After release, a subsequent 0x5A is received with rx_data=0x5A and no error flags.

Source files
------------

// File: rtl/uart_rx_core.sv
// ============================================================================
// uart_rx_core
// ----------------------------------------------------------------------------
// Oversampling UART receiver. The serial line is synchronised, a free-running
// divider produces baud ticks, and an FSM validates the start bit at its
// midpoint, samples every following bit at its midpoint, and commits the
// assembled word into a one-word valid/ready output buffer.
//
// Optional feature: define UART_RX_PARITY_EN to add a parity bit between the
// data bits and the stop bit(s). Without it, parity_err is tied to 0.
//
// Parameters:
//   DATA_BITS   data bits per frame (5..9)
//   STOP_BITS   stop bits per frame (1 or 2)
//   OVERSAMPLE  baud ticks per bit (even, 8..32)
//   CLK_DIV     clk cycles per baud tick (>= 2)
//   PARITY_ODD  1 = odd parity, 0 = even parity (parity build only)
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   rx          serial input, asynchronous to clk, idles high
//   rx_data     received word (first bit on the line is bit 0)
//   rx_valid    rx_data / frame_err / parity_err hold a word
//   rx_ready    consumer accepts the word this cycle
//   frame_err   a stop bit was sampled low (qualified by rx_valid)
//   parity_err  parity mismatch (qualified by rx_valid)
//   overrun     sticky: a completed word was dropped because the buffer was full
//   ovr_clr     single-cycle clear of overrun (a simultaneous set wins)
//   busy        receiver FSM is outside IDLE
// ============================================================================
module uart_rx_core #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int CLK_DIV    = 27,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    input  logic                 ovr_clr,
    output logic                 busy
);

    localparam int TICK_W = $clog2(CLK_DIV);
    localparam int SCNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = 4;

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------------
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_core: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_core: STOP_BITS must be 1 or 2");
    end
    if (OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("uart_rx_core: OVERSAMPLE must be even and 8..32");
    end
    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("uart_rx_core: CLK_DIV must be at least 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_rx_core: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_BREAK
    } state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic                 r_rx_meta;
    logic                 r_rx_sync;
    logic [TICK_W-1:0]    r_tick_cnt;
    logic                 w_tick;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [SCNT_W-1:0]    r_scnt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_ferr_lat;

    logic                 w_scnt_half;
    logic                 w_scnt_full;
    logic                 w_mid_bit;
    logic                 w_last_data;
    logic                 w_last_stop;
    logic                 w_ferr_now;

    logic                 w_busy;
    logic                 w_sample_data;
    logic                 w_sample_stop;
    logic                 w_commit;
    logic                 w_buf_free;

    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

`ifdef UART_RX_PARITY_EN
    logic                 r_par_bit;
    logic                 r_parity_err;
    logic                 w_sample_par;
    logic                 w_par_err_now;
`endif

    // ------------------------------------------------------------------------
    // Input synchroniser. Resets to the idle level so that reset release is
    // never mistaken for a start bit.
    // ------------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking (<=) assignments so all
    // flops update together from pre-edge values; blocking assignments here
    // would let r_rx_sync see this cycle's r_rx_meta and collapse the chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Baud tick divider: free-running 0..CLK_DIV-1, tick on the last count.
    // ------------------------------------------------------------------------
    assign w_tick = (r_tick_cnt == TICK_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Sample-point decodes shared by the FSM and datapath
    // ------------------------------------------------------------------------
    assign w_scnt_half = (r_scnt == SCNT_W'(OVERSAMPLE / 2 - 1));
    assign w_scnt_full = (r_scnt == SCNT_W'(OVERSAMPLE - 1));
    assign w_mid_bit   = w_tick && w_scnt_full;
    assign w_last_data = (r_bit_cnt == BIT_W'(DATA_BITS - 1));
    assign w_last_stop = (r_bit_cnt == BIT_W'(STOP_BITS - 1));
    // Frame error including the stop sample being taken this very cycle.
    assign w_ferr_now  = r_ferr_lat || !r_rx_sync;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    // NOTE: w_state_nxt gets a default before the case so that every path
    // assigns it; a missing assignment on any path would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_tick && !r_rx_sync) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                // Line back high at the start-bit midpoint means a glitch.
                if (w_tick && w_scnt_half) begin
                    w_state_nxt = r_rx_sync ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_mid_bit && w_last_data) begin
`ifdef UART_RX_PARITY_EN
                    w_state_nxt = ST_PARITY;
`else
                    w_state_nxt = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_mid_bit) begin
                    w_state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // A clean frame returns to IDLE at the last stop midpoint so a
                // start bit arriving half a bit later is still caught.
                if (w_commit) begin
                    w_state_nxt = w_ferr_now ? ST_BREAK : ST_IDLE;
                end
            end
            ST_BREAK: begin
                // Hold here until the line idles so a stuck-low line cannot
                // produce a stream of frames.
                if (r_rx_sync) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output decode (status and datapath strobes)
    // ------------------------------------------------------------------------
    always_comb begin
        w_busy        = (r_state != ST_IDLE);
        w_sample_data = (r_state == ST_DATA) && w_mid_bit;
        w_sample_stop = (r_state == ST_STOP) && w_mid_bit;
        w_commit      = w_sample_stop && w_last_stop;
`ifdef UART_RX_PARITY_EN
        w_sample_par  = (r_state == ST_PARITY) && w_mid_bit;
`endif
    end

    // ------------------------------------------------------------------------
    // Datapath: sample counter, bit counter, shift register, error latch
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scnt     <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_ferr_lat <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_scnt     <= '0;
                    r_bit_cnt  <= '0;
                    r_ferr_lat <= 1'b0;
                end
                ST_START: begin
                    if (w_tick) begin
                        r_scnt <= w_scnt_half ? '0 : r_scnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    r_scnt <= '0;
                end
                default: begin
                    // DATA / PARITY / STOP: count ticks across one bit period.
                    if (w_tick) begin
                        r_scnt <= w_scnt_full ? '0 : r_scnt + 1'b1;
                    end
                end
            endcase

            // Right shift with the new sample entering at the MSB: after
            // DATA_BITS samples the first bit on the line sits in bit 0.
            if (w_sample_data) begin
                r_shift   <= {r_rx_sync, r_shift[DATA_BITS-1:1]};
                r_bit_cnt <= w_last_data ? '0 : r_bit_cnt + 1'b1;
            end

            if (w_sample_stop) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                if (!r_rx_sync) begin
                    r_ferr_lat <= 1'b1;
                end
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_par_bit <= 1'b0;
        end else if (w_sample_par) begin
            r_par_bit <= r_rx_sync;
        end
    end

    assign w_par_err_now = ((^r_shift) ^ (PARITY_ODD != 0)) != r_par_bit;
`endif

    // ------------------------------------------------------------------------
    // Output buffer. A commit may land in the same cycle the consumer takes
    // the previous word; in that case the new word replaces it seamlessly.
    // ------------------------------------------------------------------------
    assign w_buf_free = !r_rx_valid || rx_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else if (w_commit && w_buf_free) begin
            r_rx_data   <= r_shift;
            r_rx_valid  <= 1'b1;
            r_frame_err <= w_ferr_now;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= w_par_err_now;
`endif
        end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
        end
    end

    // Sticky overrun: a dropped commit sets it, and set beats clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overrun <= 1'b0;
        end else if (w_commit && !w_buf_free) begin
            r_overrun <= 1'b1;
        end else if (ovr_clr) begin
            r_overrun <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = w_busy;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule
